// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-byte ALU sequencer: operation codes, ALU command
// encodings and sequencer states.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_ASR = 3'd3,
        OP_LSR = 3'd4,
        OP_AND = 3'd5,
        OP_XOR = 3'd6,
        OP_PAR = 3'd7
    } op_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SHL  = 4'd2;
    localparam logic [3:0] ALU_ASR  = 4'd3;
    localparam logic [3:0] ALU_LSR  = 4'd4;
    localparam logic [3:0] ALU_ROL  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_RXOR = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXE,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Runs 1..NBYTES byte operations through the external 8-bit ALU, one byte per pass.
// Define ALU_SEQ_PARITY_EN to enable the PAR (reduction parity) operation.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int ADDR_W = 8,
    localparam int LW = $clog2(NBYTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [LW-1:0]     len_i,
    input  logic [ADDR_W-1:0] a_base_i,
    input  logic [ADDR_W-1:0] b_base_i,
    input  logic [ADDR_W-1:0] r_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              carry_o,
    output logic              parity_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [3:0]        alu_cmd_o,
    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic              alu_sc_o,
    output logic              alu_pari_o,
    input  logic [7:0]        alu_rslt_i,
    input  logic              alu_sc_i,
    input  logic              alu_sc_clr_i,
    input  logic              alu_sc_en_i,
    input  logic              alu_pari_i,
    input  logic              alu_pari_en_i,
    input  logic              alu_pari_clr_i
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [LW-1:0]       len_q, k_q, idx;
    logic [ADDR_W-1:0]   a_base_q, b_base_q, r_base_q, idx_ext;
    logic [7:0]          a_lat_q;
    logic                sc_q, sc_d, err_q, carry_q;
    logic                binary, msb_first, last, op_ok, bad_start, accept, pari_chain;

    assign binary    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_XOR);
    assign msb_first = (op_q == OP_ASR) || (op_q == OP_LSR) || (op_q == OP_PAR);
    assign last      = (k_q == len_q - LW'(1));
    assign idx       = msb_first ? (len_q - LW'(1) - k_q) : k_q;
    assign idx_ext   = ADDR_W'(idx);
    assign accept    = (state_q == S_IDLE) && start_i;

`ifdef ALU_SEQ_PARITY_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (op_i != OP_PAR);
`endif
    // Lengths beyond NBYTES are rejected the same way as a zero length.
    assign bad_start = (len_i == '0) || (len_i > LW'(NBYTES)) || !op_ok;

    assign sc_d     = alu_sc_clr_i ? 1'b0 : (alu_sc_en_i ? alu_sc_i : sc_q);
    assign busy_o   = (state_q == S_RDA) || (state_q == S_RDB) || (state_q == S_EXE);
    assign done_o   = (state_q == S_DONE);
    assign err_o    = err_q;
    assign carry_o  = carry_q;

    always_comb begin
        state_d    = state_q;
        rd_addr_o  = '0;
        wr_en_o    = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        alu_cmd_o  = ALU_ADD;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_sc_o   = 1'b0;
        alu_pari_o = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) state_d = bad_start ? S_DONE : S_RDA;
            S_RDA: begin
                rd_addr_o = a_base_q + idx_ext;
                state_d   = binary ? S_RDB : S_EXE;
            end
            S_RDB: begin
                rd_addr_o = b_base_q + idx_ext;
                state_d   = S_EXE;
            end
            S_EXE: begin
                alu_a_o    = binary ? a_lat_q : rd_data_i;
                // Subtract as A + ~B + 1: the +1 comes from the carry preset at start.
                alu_b_o    = (op_q == OP_SUB) ? ~rd_data_i : rd_data_i;
                alu_sc_o   = sc_q;
                alu_pari_o = pari_chain;
                wr_en_o    = (op_q != OP_PAR);
                wr_addr_o  = r_base_q + idx_ext;
                wr_data_o  = alu_rslt_i;
                case (op_q)
                    OP_SHL:  alu_cmd_o = ALU_SHL;
                    OP_ASR:  alu_cmd_o = (k_q == '0) ? ALU_ASR : ALU_LSR;
                    OP_LSR:  alu_cmd_o = ALU_LSR;
                    OP_AND:  alu_cmd_o = ALU_AND;
                    OP_XOR:  alu_cmd_o = ALU_XOR;
                    OP_PAR:  alu_cmd_o = ALU_RXOR;
                    default: alu_cmd_o = ALU_ADD;
                endcase
                state_d = last ? S_DONE : S_RDA;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            len_q    <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            r_base_q <= '0;
            a_lat_q  <= '0;
            sc_q     <= 1'b0;
            err_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start_i) begin
                    op_q     <= op_e'(op_i);
                    len_q    <= len_i;
                    k_q      <= '0;
                    a_base_q <= a_base_i;
                    b_base_q <= b_base_i;
                    r_base_q <= r_base_i;
                    err_q    <= bad_start;
                    if (!bad_start) sc_q <= (op_i == OP_SUB);
                end
                S_RDB: a_lat_q <= rd_data_i;
                S_EXE: begin
                    sc_q <= sc_d;
                    k_q  <= k_q + LW'(1);
                    if (last) carry_q <= sc_d;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_PARITY_EN
    logic par_q, par_d, parity_q;

    assign par_d      = alu_pari_clr_i ? 1'b0 : (alu_pari_en_i ? alu_pari_i : par_q);
    assign pari_chain = par_q;
    assign parity_o   = parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q    <= 1'b0;
            parity_q <= 1'b0;
        end else if (accept && !bad_start) begin
            par_q <= 1'b0;
        end else if (state_q == S_EXE) begin
            par_q <= par_d;
            if (last) parity_q <= par_d;
        end
    end
`else
    logic unused_pari;
    assign unused_pari = ^{alu_pari_i, alu_pari_en_i, alu_pari_clr_i, accept};
    assign pari_chain  = 1'b0;
    assign parity_o    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural 8-bit ALU and a
// registered-read byte memory; expected results come from whole-word arithmetic.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 0, rst_n = 0, start_i = 0;
    logic [2:0] op_i = 0, len_i = 0;
    logic [7:0] a_base_i = 0, b_base_i = 0, r_base_i = 0;
    logic       busy_o, done_o, err_o, carry_o, parity_o, wr_en_o;
    logic [7:0] rd_addr_o, wr_addr_o, wr_data_o, rd_data_i, alu_a_o, alu_b_o, alu_rslt_i;
    logic [3:0] alu_cmd_o;
    logic       alu_sc_o, alu_pari_o, alu_sc_i, alu_sc_clr_i, alu_sc_en_i;
    logic       alu_pari_i, alu_pari_en_i, alu_pari_clr_i;

    alu_seq_ctrl #(.NBYTES(4), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .len_i(len_i),
        .a_base_i(a_base_i), .b_base_i(b_base_i), .r_base_i(r_base_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .carry_o(carry_o), .parity_o(parity_o),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .alu_cmd_o(alu_cmd_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_sc_o(alu_sc_o), .alu_pari_o(alu_pari_o),
        .alu_rslt_i(alu_rslt_i), .alu_sc_i(alu_sc_i), .alu_sc_clr_i(alu_sc_clr_i),
        .alu_sc_en_i(alu_sc_en_i), .alu_pari_i(alu_pari_i), .alu_pari_en_i(alu_pari_en_i),
        .alu_pari_clr_i(alu_pari_clr_i)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_rslt_i = 8'h00; alu_sc_i = 1'b0; alu_sc_en_i = 1'b0; alu_sc_clr_i = 1'b0;
        alu_pari_i = 1'b0; alu_pari_en_i = 1'b0; alu_pari_clr_i = 1'b0;
        case (alu_cmd_o)
            4'd0: begin {alu_sc_i, alu_rslt_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {8'd0, alu_sc_o}; alu_sc_en_i = 1'b1; end
            4'd2: begin alu_rslt_i = {alu_a_o[6:0], alu_sc_o}; alu_sc_i = alu_a_o[7]; alu_sc_en_i = 1'b1; end
            4'd3: begin alu_rslt_i = {alu_a_o[7], alu_a_o[7:1]}; alu_sc_i = alu_a_o[0]; alu_sc_en_i = 1'b1; end
            4'd4: begin alu_rslt_i = {alu_sc_o, alu_a_o[7:1]}; alu_sc_i = alu_a_o[0]; alu_sc_en_i = 1'b1; end
            4'd6: begin alu_rslt_i = alu_a_o & alu_b_o; alu_sc_clr_i = 1'b1; end
            4'd7: begin alu_rslt_i = alu_a_o ^ alu_b_o; alu_sc_clr_i = 1'b1; end
            4'd8: begin alu_pari_i = (^alu_a_o) ^ alu_pari_o; alu_pari_en_i = 1'b1; end
            default: ;
        endcase
    end

    // Memory: registered read, writes from DUT or bench preload
    logic [7:0] mem [256];
    logic       pl_en = 0;
    logic [7:0] pl_addr = 0, pl_data = 0;
    int         cyc = 0, wr_cnt = 0;

    always @(posedge clk) begin
        rd_data_i <= mem[rd_addr_o];
        if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
        else if (pl_en) mem[pl_addr] <= pl_data;
        cyc <= cyc + 1;
        if (wr_en_o) wr_cnt <= wr_cnt + 1;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic        car, par, err;
        int          len, rb, lat, t0, w0, nwr;
    } exp_t;

    exp_t sb[$];
    logic mcar = 0, mpar = 0;

    exp_t        me;
    logic [31:0] mgot;
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                me = sb.pop_front();
                chk({me.tag, "_lat"}, 64'(cyc - me.t0), 64'(me.lat));
                chk({me.tag, "_err"}, err_o, me.err);
                chk({me.tag, "_carry"}, carry_o, me.car);
                chk({me.tag, "_parity"}, parity_o, me.par);
                chk({me.tag, "_busy"}, busy_o, 0);
                chk({me.tag, "_nwr"}, 64'(wr_cnt - me.w0), 64'(me.nwr));
                if (me.nwr > 0) begin
                    mgot = 0;
                    for (int k = 0; k < me.len; k++) mgot[8*k +: 8] = mem[8'(me.rb + k)];
                    chk({me.tag, "_r"}, mgot, me.r);
                end
            end
        end
    end

    task automatic pl(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1; pl_addr = a; pl_data = d;
    endtask

    task automatic launch(input string tag, input int op, input int len, input int ab,
                          input int bb, input int rb, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m, av, bv, s;
        int          nb;
        bit          bin;
        nb  = 8 * len;
        m   = (64'd1 << nb) - 1;
        av  = 64'(a) & m;
        bv  = 64'(b) & m;
        bin = (op == 0) || (op == 1) || (op == 5) || (op == 6);
        e.tag = tag; e.len = len; e.rb = rb;
        e.err = (len == 0) || (op == 7 && !PAR_ON);
        e.lat = e.err ? 1 : (bin ? 3 * len + 1 : 2 * len + 1);
        e.nwr = (e.err || op == 7) ? 0 : len;
        s = 0; e.car = 0; e.par = 0;
        case (op)
            0: begin s = av + bv; e.car = s[nb]; end
            1: begin s = av + (~bv & m) + 1; e.car = s[nb]; end
            2: begin s = av << 1; e.car = av[nb-1]; end
            3: begin s = (av >> 1) | (64'(av[nb-1]) << (nb - 1)); e.car = av[0]; end
            4: begin s = av >> 1; e.car = av[0]; end
            5: s = av & bv;
            6: s = av ^ bv;
            default: e.par = ^av;
        endcase
        e.r = 32'(s & m);
        if (e.err) begin e.car = mcar; e.par = mpar; end
        mcar = e.car; mpar = e.par;
        for (int k = 0; k < len; k++) begin
            pl(8'(ab + k), av[8*k +: 8]);
            pl(8'(bb + k), bv[8*k +: 8]);
            pl(8'(rb + k), 8'hEE);
        end
        @(negedge clk);
        pl_en = 0;
        op_i = 3'(op); len_i = 3'(len); a_base_i = 8'(ab); b_base_i = 8'(bb); r_base_i = 8'(rb);
        e.t0 = cyc; e.w0 = wr_cnt;
        sb.push_back(e);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 1, 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_op(input string tag, input int op, input int len, input int ab,
                          input int bb, input int rb, input logic [31:0] a, input logic [31:0] b);
        launch(tag, op, len, ab, bb, rb, a, b);
        wait_done(tag);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_carry", carry_o, 0);
        chk("rst_parity", parity_o, 0);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_alu_cmd", alu_cmd_o, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        run_op("add2", 0, 2, 8'h10, 8'h30, 8'h50, 32'h01FF, 32'h0001);
        run_op("sub_borrow", 1, 1, 8'h10, 8'h30, 8'h50, 32'h00, 32'h01);
        run_op("sub_ok", 1, 1, 8'h10, 8'h30, 8'h50, 32'h05, 32'h03);
        run_op("len0", 0, 0, 8'h10, 8'h30, 8'h50, 32'h0, 32'h0);
        run_op("asr2", 3, 2, 8'h10, 8'h30, 8'h50, 32'h8001, 32'h0);
        run_op("lsr2", 4, 2, 8'h10, 8'h30, 8'h50, 32'h8001, 32'h0);
        run_op("shl2", 2, 2, 8'h10, 8'h30, 8'h50, 32'h8001, 32'h0);
        run_op("and3", 5, 3, 8'h10, 8'h30, 8'h50, 32'hF0F0F0, 32'h3C3C3C);
        run_op("xor3", 6, 3, 8'h10, 8'h30, 8'h50, 32'hF0F0F0, 32'h3C3C3C);
        run_op("par3", 7, 3, 8'h10, 8'h30, 8'h50, 32'h000007, 32'h0);
        run_op("wrap_a", 0, 4, 8'hFE, 8'h40, 8'h60, 32'h89ABCDEF, 32'h76543211);
        run_op("wrap_r", 1, 4, 8'h20, 8'h40, 8'hFE, 32'h12345678, 32'h87654321);

        // Start pulses while busy must not disturb the running op
        launch("ignore", 0, 2, 8'h10, 8'h30, 8'h50, 32'h1234, 32'h1111);
        @(negedge clk);
        start_i = 1; op_i = 3'd6; len_i = 3'd1; a_base_i = 8'h99; b_base_i = 8'h99; r_base_i = 8'h10;
        @(negedge clk);
        start_i = 0;
        chk("ignore_busy", busy_o, 1);
        wait_done("ignore");

        for (int i = 0; i < 12; i++)
            run_op("rnd", $urandom_range(0, 6), $urandom_range(1, 4), 8'h10, 8'h30, 8'h50,
                   $urandom, $urandom);

        // Async reset during EXE of byte 1 of a 4-byte ADD
        launch("abort", 0, 4, 8'h10, 8'h30, 8'h50, 32'h01020304, 32'h10101010);
        sb.delete();
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (wr_en_o) n++;
            if (n < 2) @(negedge clk);
        end
        chk("abort_seen_exe", n, 2);
        rst_n = 0;
        #1;
        chk("abort_wr_en", wr_en_o, 0);
        chk("abort_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1;
        mcar = 0; mpar = 0;
        repeat (15) @(negedge clk);
        chk("abort_b0", mem[8'h50], 8'h14);
        chk("abort_b1", mem[8'h51], 8'hEE);
        chk("abort_b2", mem[8'h52], 8'hEE);
        chk("abort_b3", mem[8'h53], 8'hEE);
        chk("abort_idle", busy_o, 0);

        run_op("post_rst", 0, 1, 8'h10, 8'h30, 8'h50, 32'h7F, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
